// File: rtl/ntt_intt_ip_coef_io_if.sv
// Signal bundle of the coefficient mover: command strobes, input stream, RAM port, output stream, status.
// The mover itself uses the slave modport; master is the view of whatever drives it.
interface ntt_intt_ip_coef_io_if #(
    parameter int CW = 12,
    parameter int AW = 8
);
    logic          load_i;
    logic          store_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [CW-1:0] in_data_i;
    logic          load_en_o;
    logic          mem_we_o;
    logic          mem_re_o;
    logic [AW-1:0] mem_addr_o;
    logic [CW-1:0] mem_wdata_o;
    logic [CW-1:0] mem_rdata_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] out_data_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    modport slave (
        input  load_i, store_i, in_valid_i, in_data_i, mem_rdata_i, out_ready_i,
        output in_ready_o, load_en_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
               out_valid_o, out_data_o, busy_o, done_o, err_o
    );

    modport master (
        output load_i, store_i, in_valid_i, in_data_i, mem_rdata_i, out_ready_i,
        input  in_ready_o, load_en_o, mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o,
               out_valid_o, out_data_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/ntt_intt_ip_coef_io.sv
// Coefficient load/store mover between the coefficient streams and the polynomial RAM.
// Optional input range check is built only when NTT_INTT_COEF_RANGE_CHECK_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for load_i / store_i (load_i has priority)
// ST_LOAD  | accepting N_COEF input beats, one RAM write + load_en per beat
// ST_STORE | reading RAM 0..N_COEF-1 through a 2-entry FIFO to the output
module ntt_intt_ip_coef_io #(
    parameter int N_COEF = 256,
    parameter int CW     = 12,
    parameter int AW     = 8,
    parameter int Q      = 3329
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ntt_intt_ip_coef_io_if.slave   io
);
    localparam int              CNTW = AW + 1;
    localparam logic [CNTW-1:0] NUM  = CNTW'(N_COEF);
    localparam logic [CNTW-1:0] LAST = CNTW'(N_COEF - 1);

    if (N_COEF != (1 << AW)) begin : g_bad_aw
        $error("N_COEF must equal 2**AW");
    end
    if (Q < 2 || Q >= (1 << CW)) begin : g_bad_q
        $error("Q must fit in CW bits");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNTW-1:0] out_cnt_q, out_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            arm_q, arm_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   fifo_q [2];
    logic [CW-1:0]   fifo_d [2];
    logic            wp_q, wp_d, rp_q, rp_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic            done_q, done_d;
    logic            accept, issue, push, pop;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        arm_d      = arm_q;
        fifo_d     = fifo_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        done_d     = 1'b0;

        accept = (state_q == ST_LOAD) && io.in_valid_i;
        // The first STORE cycle only arms the read port, so the first beat
        // shows up on the third edge after the one that sampled store_i.
        issue  = (state_q == ST_STORE) && arm_q && (rd_cnt_q < NUM) &&
                 (({1'b0, fcnt_q} + {2'b00, inflight_q}) < 3'd2);
        push   = inflight_q;
        pop    = (fcnt_q != 2'd0) && io.out_ready_i;

        case (state_q)
            ST_IDLE: begin
                if (io.load_i) begin
                    state_d = ST_LOAD;
                end else if (io.store_i) begin
                    state_d = ST_STORE;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                arm_d = 1'b1;
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            arm_d     = 1'b0;
        end

        inflight_d = issue;
        if (push) begin
            fifo_d[wp_q] = io.mem_rdata_i;
            wp_d         = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};

        addr_d = accept ? wr_cnt_q[AW-1:0] :
                 issue  ? rd_cnt_q[AW-1:0] : addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            addr_q     <= '0;
            arm_q      <= 1'b0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            fcnt_q     <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            addr_q     <= addr_d;
            arm_q      <= arm_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            fcnt_q     <= fcnt_d;
            done_q     <= done_d;
        end
    end

    assign io.in_ready_o  = (state_q == ST_LOAD);
    assign io.load_en_o   = accept;
    assign io.mem_we_o    = accept;
    assign io.mem_re_o    = issue;
    assign io.mem_addr_o  = addr_d;
    assign io.mem_wdata_o = accept ? io.in_data_i : '0;
    assign io.out_valid_o = (fcnt_q != 2'd0);
    assign io.out_data_o  = (fcnt_q != 2'd0) ? fifo_q[rp_q] : '0;
    assign io.busy_o      = (state_q != ST_IDLE);
    assign io.done_o      = done_q;

`ifdef NTT_INTT_COEF_RANGE_CHECK_EN
    logic err_q, err_d;

    // Out-of-range coefficients are still written; the flag only reports them.
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_IDLE) && io.load_i) begin
            err_d = 1'b0;
        end else if (accept && (32'(io.in_data_i) >= 32'(Q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign io.err_o = err_q;
`else
    assign io.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_intt_ip_coef_io.sv
// Self-checking bench for ntt_intt_ip_coef_io: cycle table for reset/priority/strobes,
// then scoreboarded LOAD/STORE sequences, range check and mid-load reset abort.
module tb_ntt_intt_ip_coef_io;
    localparam int N  = 256;
    localparam int CW = 12;
    localparam int AW = 8;
    localparam int QV = 3329;
`ifdef NTT_INTT_COEF_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_ni;

    ntt_intt_ip_coef_io_if #(.CW(CW), .AW(AW)) io();

    ntt_intt_ip_coef_io #(.N_COEF(N), .CW(CW), .AW(AW), .Q(QV)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    // Polynomial RAM model with one cycle of read latency.
    logic [CW-1:0] ram [N];
    always @(posedge clk) begin
        if (io.mem_we_o) ram[io.mem_addr_o] <= io.mem_wdata_o;
        if (io.mem_re_o) io.mem_rdata_i <= ram[io.mem_addr_o];
    end

    typedef struct {
        bit            rst_n, load, store, vld;
        logic [CW-1:0] data;
        bit            e_busy, e_rdy, e_we, e_done;
        logic [AW-1:0] e_addr;
        logic [CW-1:0] e_wdata;
    } vec_t;

    logic [AW+CW-1:0] exp_wr_q[$];
    logic [CW-1:0]    exp_rd_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_we = 0;
    bit mon_en = 1'b0;
    bit hold_pend = 1'b0;
    bit exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input int val);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected none", nm, val);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check();
        logic [AW+CW-1:0] w;
        @(negedge clk);
        if (!mon_en) return;
        if (io.mem_we_o) begin
            n_we++;
            if (exp_wr_q.size() == 0) begin
                flag("wr_unexpected", int'(io.mem_addr_o));
            end else begin
                w = exp_wr_q.pop_front();
                chk("wr_addr", io.mem_addr_o, w[AW+CW-1:CW]);
                chk("wr_data", io.mem_wdata_o, w[CW-1:0]);
                chk("load_en", io.load_en_o, 1);
            end
        end
        if (hold_pend) chk("out_held", io.out_valid_o, 1);
        hold_pend = 1'b0;
        if (io.out_valid_o) begin
            if (exp_rd_q.size() == 0) begin
                flag("out_unexpected", int'(io.out_data_o));
            end else begin
                chk("out_data", io.out_data_o, exp_rd_q[0]);
                if (io.out_ready_i) void'(exp_rd_q.pop_front());
                else hold_pend = 1'b1;
            end
        end
    endtask

    task automatic do_load(input bit gaps, input int mult, input int bad_idx);
        int i = 0;
        int we0;
        bit tog = 1'b0;
        bit vld;
        logic [CW-1:0] d;
        cyc();
        io.load_i = 1'b1;
        tick_check();
        chk("load_err_pre", io.err_o, exp_err);
        exp_err = 1'b0;
        we0 = n_we;
        cyc();
        io.load_i = 1'b0;
        for (int c = 0; c < 1200 && i < N; c++) begin
            vld = gaps ? tog : 1'b1;
            tog = ~tog;
            d = (i == bad_idx) ? CW'(QV) : CW'(i * mult);
            io.in_valid_i = vld;
            io.in_data_i  = d;
            if (vld) exp_wr_q.push_back({AW'(i), d});
            tick_check();
            chk("load_ready", io.in_ready_o, 1);
            chk("load_err", io.err_o, exp_err);
            if (vld) begin
                if (i == N - 1) chk("done_early", io.done_o, 0);
                if (i == bad_idx) exp_err = RC;
                i++;
            end
            if (i < N) cyc();
        end
        if (i < N) flag("load_timeout", i);
        cyc();
        io.in_valid_i = 1'b0;
        io.in_data_i  = '0;
        tick_check();
        chk("load_done", io.done_o, 1);
        chk("load_idle", io.busy_o, 0);
        chk("load_ready_idle", io.in_ready_o, 0);
        chk("load_strobes", n_we - we0, N);
        chk("load_err_post", io.err_o, exp_err);
        cyc();
        tick_check();
        chk("load_done_pulse", io.done_o, 0);
    endtask

    task automatic do_store(input bit rnd);
        int k = 0;
        int lat = -1;
        for (int a = 0; a < N; a++) exp_rd_q.push_back(CW'(3 * a));
        cyc();
        io.store_i = 1'b1;
        io.out_ready_i = 1'b1;
        tick_check();
        cyc();
        io.store_i = 1'b0;
        while (exp_rd_q.size() != 0 && k < 3000) begin
            k++;
            io.out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick_check();
            // k counts cycles starting at the edge that sampled store_i
            if (lat < 0 && io.out_valid_o) lat = k - 1;
            if (exp_rd_q.size() != 0) cyc();
        end
        if (exp_rd_q.size() != 0) begin
            flag("store_timeout", exp_rd_q.size());
            exp_rd_q.delete();
        end
        if (!rnd) begin
            chk("store_first_valid", lat, 3);
            chk("store_rate", (k <= 4 + 2 * (N - 1)), 1);
        end
        cyc();
        io.out_ready_i = 1'b0;
        tick_check();
        chk("store_done", io.done_o, 1);
        chk("store_idle", io.busy_o, 0);
        chk("store_empty", io.out_valid_o, 0);
        cyc();
        tick_check();
        chk("store_done_pulse", io.done_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        rst_ni = 1'b0;
        io.load_i = 1'b0;
        io.store_i = 1'b0;
        io.in_valid_i = 1'b0;
        io.in_data_i = '0;
        io.out_ready_i = 1'b0;

        //           rst ld st vld data busy rdy we done addr wdata
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'd5,  1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 12'd5};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 12'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'd7,  1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 12'd7};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 12'd0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'd9,  1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 12'd9};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0};

        for (int r = 0; r < 10; r++) begin
            cyc();
            rst_ni        = tbl[r].rst_n;
            io.load_i     = tbl[r].load;
            io.store_i    = tbl[r].store;
            io.in_valid_i = tbl[r].vld;
            io.in_data_i  = tbl[r].data;
            tick_check();
            chk($sformatf("t%0d_busy", r),     io.busy_o,      tbl[r].e_busy);
            chk($sformatf("t%0d_in_ready", r), io.in_ready_o,  tbl[r].e_rdy);
            chk($sformatf("t%0d_we", r),       io.mem_we_o,    tbl[r].e_we);
            chk($sformatf("t%0d_load_en", r),  io.load_en_o,   tbl[r].e_we);
            chk($sformatf("t%0d_done", r),     io.done_o,      tbl[r].e_done);
            chk($sformatf("t%0d_addr", r),     io.mem_addr_o,  tbl[r].e_addr);
            chk($sformatf("t%0d_wdata", r),    io.mem_wdata_o, tbl[r].e_wdata);
            chk($sformatf("t%0d_re", r),       io.mem_re_o,    0);
            chk($sformatf("t%0d_out_valid", r), io.out_valid_o, 0);
            chk($sformatf("t%0d_err", r),      io.err_o,       0);
        end
        io.load_i = 1'b0;
        io.store_i = 1'b0;
        io.in_valid_i = 1'b0;
        io.in_data_i = '0;
        mon_en = 1'b1;
        exp_err = 1'b0;

        do_load(1'b0, 1, -1);
        do_load(1'b1, 3, -1);
        do_store(1'b0);
        do_store(1'b1);

        do_load(1'b0, 1, 10);
        chk("ram_bad_kept", ram[10], QV);
        do_load(1'b1, 3, -1);

        // load_i and store_i together, then reset in the middle of the load
        cyc();
        io.load_i = 1'b1;
        io.store_i = 1'b1;
        tick_check();
        chk("both_err_pre", io.err_o, exp_err);
        exp_err = 1'b0;
        cyc();
        io.load_i = 1'b0;
        io.store_i = 1'b0;
        for (int b = 0; b < 100; b++) begin
            io.in_valid_i = 1'b1;
            io.in_data_i = CW'(1000 + b);
            exp_wr_q.push_back({AW'(b), CW'(1000 + b)});
            tick_check();
            if (b == 0) begin
                chk("prio_load_ready", io.in_ready_o, 1);
                chk("prio_no_read", io.mem_re_o, 0);
            end
            cyc();
        end
        io.in_valid_i = 1'b1;
        io.in_data_i = CW'(1100);
        rst_ni = 1'b0;
        #1;
        chk("abort_busy", io.busy_o, 0);
        chk("abort_in_ready", io.in_ready_o, 0);
        chk("abort_we", io.mem_we_o, 0);
        chk("abort_load_en", io.load_en_o, 0);
        chk("abort_re", io.mem_re_o, 0);
        chk("abort_addr", io.mem_addr_o, 0);
        chk("abort_wdata", io.mem_wdata_o, 0);
        chk("abort_out_valid", io.out_valid_o, 0);
        chk("abort_out_data", io.out_data_o, 0);
        chk("abort_done", io.done_o, 0);
        chk("abort_err", io.err_o, 0);
        tick_check();
        cyc();
        rst_ni = 1'b1;
        io.in_valid_i = 1'b0;
        io.in_data_i = '0;
        for (int c = 0; c < 4; c++) begin
            tick_check();
            chk("abort_no_done", io.done_o, 0);
            chk("abort_idle", io.busy_o, 0);
            cyc();
        end
        chk("abort_ram_kept", ram[99], 1099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
